// File: rtl/ssd_pkg.sv
// ssd_pkg -- shared constants and types for the seven-segment scan controller.
//   SEG_HEX     : active-low gfedcba segment patterns for hex digits 0..F
//   SEG_BLANK   : all segments off
//   AN_OFF      : all anodes off
//   digit_idx_t : index of the digit slot being scanned (0 = rightmost)
package ssd_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'hF;

    // Element 15 is listed first so that SEG_HEX[n] is the pattern for digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0010000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// ssd_scan_ctrl_if -- CPU-side load handshake and board-side display pins.
//   val_in : 16-bit value to display (digit 0 = val_in[3:0])
//   load   : single-cycle request to capture val_in
//   blank  : force all anodes off while high
//   busy   : a captured value is waiting for the next frame boundary
//   frame  : one-cycle pulse per frame boundary
//   c      : segments, active-low, c[0]=a .. c[6]=g
//   an     : anodes, active-low, an[0] = rightmost digit
// Handshake: load is a request with no ready; every cycle with load=1 is
// accepted and overwrites the pending value. busy tells the producer that an
// accepted value has not yet reached the display.
interface ssd_scan_ctrl_if;

    logic [15:0] val_in;
    logic        load;
    logic        blank;
    logic        busy;
    logic        frame;
    logic [6:0]  c;
    logic [3:0]  an;

    modport master (
        output val_in, load, blank,
        input  busy, frame, c, an
    );

    modport slave (
        input  val_in, load, blank,
        output busy, frame, c, an
    );

endinterface

// File: rtl/ssd_hex_decode.sv
// ssd_hex_decode -- combinational hex nibble to active-low segment decode.
//   nibble : 4-bit hex digit
//   seg    : active-low gfedcba pattern
module ssd_hex_decode
    import ssd_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl -- 4-digit seven-segment scan controller with tear-free
// value updates.
//   clk, reset : clock and synchronous active-high reset
//   bus        : ssd_scan_ctrl_if.slave (val_in/load/blank in,
//                busy/frame/c/an out)
// Parameters: DIV_MAX clk cycles per digit slot; CNT_W divider width.
// Optional feature macro SSD_LEADING_ZERO_BLANK_EN: when defined, digits 3..1
// show blank segments while they and every digit left of them are zero.
module ssd_scan_ctrl
    import ssd_pkg::*;
#(
    parameter int DIV_MAX = 100000,
    parameter int CNT_W   = $clog2(DIV_MAX)
) (
    input  logic           clk,
    input  logic           reset,
    ssd_scan_ctrl_if.slave bus
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    digit_idx_t       idx_q, idx_d;
    logic [15:0]      disp_q, disp_d;
    logic [15:0]      pend_q, pend_d;
    logic             busy_q, busy_d;
    logic             frame_q, frame_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       c_q, c_d;

    logic             tick;
    logic             boundary;
    logic [3:0]       cur_nibble;
    logic [6:0]       cur_seg;
    logic             digit_blank;

    assign tick       = (cnt_q == CNT_W'(DIV_MAX - 1));
    assign boundary   = tick && (idx_q == 2'd3);
    assign cur_nibble = 4'(disp_q >> {idx_q, 2'b00});

    ssd_hex_decode u_dec (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

`ifdef SSD_LEADING_ZERO_BLANK_EN
    logic [15:0] upper_nibbles;
    // Current digit and everything to its left; digit 0 is never suppressed.
    assign upper_nibbles = disp_q >> {idx_q, 2'b00};
    assign digit_blank   = (idx_q != 2'd0) && (upper_nibbles == 16'h0000);
`else
    assign digit_blank   = 1'b0;
`endif

    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        idx_d   = tick ? idx_q + 2'd1 : idx_q;  // 3 wraps to 0
        frame_d = boundary;
        disp_d  = disp_q;
        pend_d  = pend_q;
        busy_d  = busy_q;

        // Commit uses the pend value from before this edge, so a load on the
        // same cycle lands in pend and stays pending for the next frame.
        if (boundary && busy_q) begin
            disp_d = pend_q;
            busy_d = 1'b0;
        end
        if (bus.load) begin
            pend_d = bus.val_in;
            busy_d = 1'b1;
        end

        if (bus.blank) begin
            an_d = AN_OFF;
            c_d  = SEG_BLANK;
        end else begin
            an_d = ~(4'b0001 << idx_q);
            c_d  = digit_blank ? SEG_BLANK : cur_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            pend_q  <= '0;
            busy_q  <= 1'b0;
            frame_q <= 1'b0;
            an_q    <= AN_OFF;
            c_q     <= SEG_BLANK;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            pend_q  <= pend_d;
            busy_q  <= busy_d;
            frame_q <= frame_d;
            an_q    <= an_d;
            c_q     <= c_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.frame = frame_q;
    assign bus.an    = an_q;
    assign bus.c     = c_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// tb_ssd_scan_ctrl -- self-checking bench for ssd_scan_ctrl with DIV_MAX=4
// (4 cycles per digit, 16 cycles per frame).
module tb_ssd_scan_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   fails;

    // Expected {an, c} pairs, pushed when a frame is predicted and popped as
    // each digit slot is observed.
    logic [10:0] exp_q[$];

    ssd_scan_ctrl_if bus_if ();

    ssd_scan_ctrl #(.DIV_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference decode ----------------
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0010000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] exp_c(input logic [15:0] v, input int k);
        logic [3:0]  nib;
        logic [15:0] upper;
        nib   = 4'(v >> (4 * k));
        upper = v >> (4 * k);
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (k > 0 && upper == 16'h0000) return 7'h7F;
`else
        if (upper === 16'hxxxx) return 7'h7F;
`endif
        return hex_seg(nib);
    endfunction

    function automatic logic [3:0] exp_an(input int k);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << k);
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_frame(input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_if.frame === 1'b1) begin
                found = 1;
                break;
            end
        end
        if (!found) begin
            checks++;
            fails++;
            $display("FAIL %s: frame pulse not seen within 40 cycles", name);
        end
    endtask

    // Called at the negedge of a frame cycle: samples the four digit slots of
    // the frame that has just started.
    task automatic sample_frame(input logic [15:0] v, input string name);
        logic [10:0] exp;
        logic [10:0] got;
        for (int k = 0; k < 4; k++) exp_q.push_back({exp_an(k), exp_c(v, k)});
        for (int k = 0; k < 4; k++) begin
            if (k == 0) @(posedge clk);
            else repeat (4) @(posedge clk);
            @(negedge clk);
            exp = exp_q.pop_front();
            got = {bus_if.an, bus_if.c};
            checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL %s digit%0d: an/c got %b/%b expected %b/%b",
                         name, k, got[10:7], got[6:0], exp[10:7], exp[6:0]);
            end
        end
    endtask

    task automatic drive_load(input logic [15:0] v);
        bus_if.val_in = v;
        bus_if.load   = 1'b1;
        @(negedge clk);
        bus_if.load   = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        logic [10:0] exp;
        int          frames;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus_if.an, bus_if.c, bus_if.busy, bus_if.frame} !== {4'b1111, 7'b1111111, 2'b00}) begin
            fails++;
            $display("FAIL reset_hold: an/c/busy/frame got %b/%b/%b/%b expected 1111/1111111/0/0",
                     bus_if.an, bus_if.c, bus_if.busy, bus_if.frame);
        end
        reset = 1'b0;
        frames = 0;
        for (int j = 0; j < 32; j++) begin
            if (j < 16) exp_q.push_back({exp_an(j / 4), exp_c(16'h0000, j / 4)});
            @(posedge clk);
            @(negedge clk);
            if (j < 16) begin
                exp = exp_q.pop_front();
                checks++;
                if ({bus_if.an, bus_if.c} !== exp) begin
                    fails++;
                    $display("FAIL reset_scan cycle %0d: an/c got %b/%b expected %b/%b",
                             j, bus_if.an, bus_if.c, exp[10:7], exp[6:0]);
                end
            end
            checks++;
            if (bus_if.frame !== ((j % 16) == 15)) begin
                fails++;
                $display("FAIL reset_frame cycle %0d: frame got %b expected %b",
                         j, bus_if.frame, ((j % 16) == 15));
            end
            if (bus_if.frame === 1'b1) frames++;
        end
        checks++;
        if (frames != 2) begin
            fails++;
            $display("FAIL frame_count: got %0d expected 2 in 32 cycles", frames);
        end
    endtask

    task automatic test_load_mid_frame();
        bit   found;
        int   k;
        wait_frame("load_mid_sync");
        repeat (5) @(negedge clk);
        drive_load(16'h12AF);
        checks++;
        if (bus_if.busy !== 1'b1) begin
            fails++;
            $display("FAIL load_busy_set: busy got %b expected 1", bus_if.busy);
        end
        found = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus_if.frame === 1'b1) begin
                found = 1;
                break;
            end
            case (bus_if.an)
                4'b1110: k = 0;
                4'b1101: k = 1;
                4'b1011: k = 2;
                4'b0111: k = 3;
                default: k = -1;
            endcase
            checks++;
            if (k < 0 || bus_if.c !== exp_c(16'h0000, k)) begin
                fails++;
                $display("FAIL load_no_tear: an/c got %b/%b while old value 0000 shown",
                         bus_if.an, bus_if.c);
            end
        end
        if (!found) begin
            checks++;
            fails++;
            $display("FAIL load_commit_frame: frame not seen within 40 cycles");
        end
        checks++;
        if (bus_if.busy !== 1'b0) begin
            fails++;
            $display("FAIL load_busy_clear: busy got %b expected 0", bus_if.busy);
        end
        sample_frame(16'h12AF, "load_12af");
    endtask

    task automatic test_back_to_back();
        wait_frame("b2b_sync");
        bus_if.val_in = 16'h1111;
        bus_if.load   = 1'b1;
        @(negedge clk);
        bus_if.val_in = 16'h2222;
        @(negedge clk);
        bus_if.load   = 1'b0;
        checks++;
        if (bus_if.busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_busy: busy got %b expected 1", bus_if.busy);
        end
        wait_frame("b2b_commit");
        sample_frame(16'h2222, "b2b_first");
        wait_frame("b2b_again");
        sample_frame(16'h2222, "b2b_second");
    endtask

    task automatic test_load_on_commit();
        wait_frame("commit_sync");
        drive_load(16'h4444);
        repeat (14) @(posedge clk);
        @(negedge clk);
        drive_load(16'h3333);  // captured on the boundary edge
        checks++;
        if ({bus_if.frame, bus_if.busy} !== 2'b11) begin
            fails++;
            $display("FAIL commit_overlap: frame/busy got %b/%b expected 1/1",
                     bus_if.frame, bus_if.busy);
        end
        sample_frame(16'h4444, "commit_old");
        wait_frame("commit_next");
        checks++;
        if (bus_if.busy !== 1'b0) begin
            fails++;
            $display("FAIL commit_busy_clear: busy got %b expected 0", bus_if.busy);
        end
        sample_frame(16'h3333, "commit_new");
    endtask

    task automatic test_random_loads();
        logic [15:0] v;
        for (int n = 0; n < 3; n++) begin
            v = 16'($urandom_range(0, 16'hFFFF));
            drive_load(v);
            wait_frame("rand_commit");
            sample_frame(v, "rand_value");
        end
        // Restore a known value for the blank scenario.
        drive_load(16'h3333);
        wait_frame("rand_restore");
    endtask

    task automatic test_blank();
        int frames;
        wait_frame("blank_sync");
        bus_if.blank = 1'b1;
        frames = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if ({bus_if.an, bus_if.c} !== {4'b1111, 7'b1111111}) begin
                fails++;
                $display("FAIL blank_cycle %0d: an/c got %b/%b expected 1111/1111111",
                         i, bus_if.an, bus_if.c);
            end
            if (bus_if.frame === 1'b1) frames++;
        end
        checks++;
        if (frames != 1) begin
            fails++;
            $display("FAIL blank_frames: got %0d expected 1 while blanked", frames);
        end
        bus_if.blank = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // 21 edges after the boundary the scan is in digit slot 1.
        checks++;
        if ({bus_if.an, bus_if.c} !== {4'b1101, exp_c(16'h3333, 1)}) begin
            fails++;
            $display("FAIL blank_resume: an/c got %b/%b expected 1101/%b",
                     bus_if.an, bus_if.c, exp_c(16'h3333, 1));
        end
    endtask

    task automatic test_reset_mid_op();
        drive_load(16'h5555);
        checks++;
        if (bus_if.busy !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_busy_set: busy got %b expected 1", bus_if.busy);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_if.busy, bus_if.an, bus_if.c} !== {1'b0, 4'b1110, exp_c(16'h0000, 0)}) begin
            fails++;
            $display("FAIL rst_mid_release: busy/an/c got %b/%b/%b expected 0/1110/%b",
                     bus_if.busy, bus_if.an, bus_if.c, exp_c(16'h0000, 0));
        end
        wait_frame("rst_mid_frame");
        checks++;
        if (bus_if.busy !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_discard: busy got %b expected 0", bus_if.busy);
        end
        sample_frame(16'h0000, "rst_mid_zero");
        drive_load(16'h0050);
        wait_frame("lz_commit");
        sample_frame(16'h0050, "lz_0050");
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        checks        = 0;
        fails         = 0;
        reset         = 1'b1;
        bus_if.val_in = 16'h0000;
        bus_if.load   = 1'b0;
        bus_if.blank  = 1'b0;

        test_reset();
        test_load_mid_frame();
        test_back_to_back();
        test_load_on_commit();
        test_random_loads();
        test_blank();
        test_reset_mid_op();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Scan controller for the 4-digit seven-segment display on the PipelineCPU board.
- Time-multiplexes a 16-bit hex value (PC low half or selected register) onto the shared segment bus `c` and the anode lines `an`.
- Takes a load handshake from the CPU-side display mux and commits the new value only at a frame boundary, so no frame is ever torn.
- Sits between the CPU debug outputs and the board pins; replaces the free-running `clkssd` scan.

Parameters:
- DIV_MAX, 100000: clk cycles per digit slot (1 kHz digit rate at 100 MHz); sim uses 4.
- CNT_W, $clog2(DIV_MAX): divider counter width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- val_in  in  16  value to display; digit 0 = val_in[3:0] (rightmost).
- load  in  1  single-cycle request to capture val_in.
- blank  in  1  force all anodes off while high.
- busy  out  1  a captured value is pending commit.
- frame  out  1  one-cycle pulse at each frame boundary.
- c  out  7  segments, active-low; c[0]=a … c[6]=g.
- an  out  4  anodes, active-low; an[0] = rightmost digit.

Behaviour:
- Interface: one clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - cnt=0, idx=0, disp=0, pend=0.
  - busy=0, frame=0.
  - an=4'b1111, c=7'b1111111.
- Divider:
  - cnt increments each cycle.
  - tick when cnt==DIV_MAX-1; cnt then wraps to 0.
- Digit index: idx advances 0→1→2→3→0 on tick only.
- Frame boundary: the tick with idx==3. On that cycle:
  - idx←0.
  - frame←1 next cycle, for one cycle.
  - If busy: disp←pend, busy←0.
- Load handshake:
  - load=1 → pend←val_in and busy←1 on the next edge.
  - load while busy overwrites pend; last write wins.
  - load on the same cycle as a commit: disp takes the old pend, pend takes val_in, busy stays 1.
- Outputs are registered, one cycle after idx/disp.
  - an = ~(1<<idx).
  - c = hex decode of disp[4*idx+3:4*idx].
- blank=1 → an=1111 and c=1111111 from the next cycle. Scanning and commits continue internally.
- Reset mid-frame or with busy=1: pending value is discarded; return to reset values.
- Hex decode, active-low gfedcba patterns:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110

Optional Feature:
- Macro: SSD_LEADING_ZERO_BLANK_EN.
- Defined: digit k (k=3..1) shows blank segments (c=1111111, anode still driven) when disp nibbles k..3 are all zero. Digit 0 is always shown.
  - disp=0x0050 → digits 3,2 blank; digits 1,0 show "50".
- Undefined: all four digits are always shown, including leading zeros.

Decomposition:
- Package ssd_pkg:
  - SEG_HEX[16] constant table.
  - SEG_BLANK = 7'h7F.
  - AN_OFF = 4'hF.
  - digit-index typedef (2 bits).
- Sub-module ssd_hex_decode: combinational 4-bit nibble → 7-bit active-low segments, reading SEG_HEX. Used once per output.
- Divider, index, handshake and output registers all live in ssd_scan_ctrl.

Test Plan (DIV_MAX=4):
- Reset release: hold reset 2 cycles, release → next cycle an=1110, c=1000000. The an sequence 1110,1101,1011,0111 repeats with 4 cycles per digit. frame pulses once every 16 cycles.
- Load 0x12AF mid-frame: busy=1 next cycle. Digits keep showing 0 until the frame boundary; then busy=0. Next frame shows digit0 c=0001110 (F), digit1 0001000 (A), digit2 0100100 (2), digit3 1111001 (1).
- Back-to-back loads: load 0x1111 then 0x2222 in the same frame → only 0x2222 is ever displayed.
- Load on commit cycle: load 0x3333 on the boundary cycle while pend=0x4444 → the frame shows 4444, the following frame shows 3333. busy stays 1 across the boundary.
- Blank: assert blank for 20 cycles → an=1111 and c=1111111 throughout. On deassert, scanning resumes at the current idx with no restart.
- Reset mid-operation: reset while busy=1 with pend=0x5555 → busy=0 and display shows 0000. With SSD_LEADING_ZERO_BLANK_EN defined, load 0x0050 → digits 3,2 show c=1111111.
